// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: host-transmitter state encoding, common command bytes
// and the odd-parity helper.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RELEASE      = 8'hF0;

  localparam int FILTER_LEN = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the keyboard controller (master) and the
// PS/2 host transmitter (slave).
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_data, output tx_valid,
                  input tx_busy, input tx_done, input tx_error);
  modport slave  (input tx_data, input tx_valid,
                  output tx_busy, output tx_done, output tx_error);

endinterface

// File: rtl/ps2_fall_detect.sv
// PS/2 clock falling-edge detector: FILTER_LEN-sample shift register that also
// acts as the synchronizer; one pulse per clean high-to-low transition.
module ps2_fall_detect
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic fall
);

  logic [FILTER_LEN-1:0] samples_r;

  // Shift in one raw line sample per clock, newest in bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      samples_r <= {FILTER_LEN{1'b0}};
    end else begin
      samples_r <= {samples_r[FILTER_LEN-2:0], line};
    end
  end

  // Four old highs followed by four new lows can only match once per edge.
  assign fall = (samples_r[7:4] == 4'hF) && (samples_r[3:0] == 4'h0);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data, parity,
// stop, ACK). Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2clk,
  input  logic         ps2data,
  output logic         ps2clk_oe,
  output logic         ps2data_oe
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cyc_r;
  logic [3:0]       cnt_r;
  logic [7:0]       data_r;
  logic             parity_r;
  logic [1:0]       data_sync_r;
  logic             clk_oe_r;
  logic             data_oe_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic             fall_s;
  logic             timeout_s;

  ps2_fall_detect u_fall (
    .clk   (clk),
    .reset (reset),
    .line  (ps2clk),
    .fall  (fall_s)
  );

`ifdef PS2_TX_TIMEOUT_EN
  assign timeout_s = (cyc_r == TIMEOUT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Transfer sequencer; every output is driven straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cyc_r       <= {CNT_W{1'b0}};
      cnt_r       <= 4'd0;
      data_r      <= 8'h00;
      parity_r    <= 1'b0;
      data_sync_r <= 2'b00;
      clk_oe_r    <= 1'b0;
      data_oe_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      data_sync_r <= {data_sync_r[0], ps2data};
      case (state_r)
        ST_IDLE: begin
          if (bus.tx_valid) begin
            data_r   <= bus.tx_data;
            parity_r <= odd_parity(bus.tx_data);
            error_r  <= 1'b0;
            busy_r   <= 1'b1;
            clk_oe_r <= 1'b1;
            cyc_r    <= {CNT_W{1'b0}};
            state_r  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cyc_r == INHIBIT_LAST) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b1;
            cyc_r     <= {CNT_W{1'b0}};
            state_r   <= ST_START;
          end else begin
            cyc_r <= cyc_r + CNT_W'(1);
          end
        end
        ST_START, ST_SEND: begin
          if (timeout_s) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            error_r   <= 1'b1;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else if (fall_s && (state_r == ST_SEND)) begin
            cyc_r <= {CNT_W{1'b0}};
            cnt_r <= cnt_r + 4'd1;
            case (cnt_r)
              4'd0, 4'd1, 4'd2, 4'd3,
              4'd4, 4'd5, 4'd6, 4'd7: data_oe_r <= ~data_r[cnt_r[2:0]];
              4'd8:  data_oe_r <= ~parity_r;
              4'd10: begin
                data_oe_r <= 1'b0;
                error_r   <= data_sync_r[1];
                done_r    <= 1'b1;
                state_r   <= ST_DONE;
              end
              default: data_oe_r <= 1'b0;
            endcase
          end else begin
            // Saturate so a silent device never wraps the counter.
            if (cyc_r != TIMEOUT_LAST) begin
              cyc_r <= cyc_r + CNT_W'(1);
            end
            if (state_r == ST_START) begin
              cnt_r   <= 4'd0;
              state_r <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2clk_oe    = clk_oe_r;
  assign ps2data_oe   = data_oe_r;
  assign bus.tx_busy  = busy_r;
  assign bus.tx_done  = done_r;
  assign bus.tx_error = error_r;

endmodule
